// File: rtl/mtr_drv_if.sv
// Motor drive bundle: speed inputs, over-current comparators and
// half-bridge drive outputs shared by the controller side and mtr_drv.
interface mtr_drv_if;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               OVR_I_lft;
    logic               OVR_I_rght;
    logic               PWM1_lft;
    logic               PWM2_lft;
    logic               PWM1_rght;
    logic               PWM2_rght;
    logic               pwm_synch;
    logic               OVR_I_shtdwn;

    modport master (
        output lft_spd, rght_spd, OVR_I_lft, OVR_I_rght,
        input  PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght,
        input  pwm_synch, OVR_I_shtdwn
    );

    modport slave (
        input  lft_spd, rght_spd, OVR_I_lft, OVR_I_rght,
        output PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght,
        output pwm_synch, OVR_I_shtdwn
    );
endinterface

// File: rtl/mtr_drv.sv
// Dual-side 11-bit complementary PWM drive with dead time and
// blanked over-current supervision latching a sticky shutdown.
module mtr_drv #(
    parameter int NONOVERLAP = 32,
    parameter int BLANK      = 128,
    parameter int OVR_LIMIT  = 4
) (
    input logic      clk,
    input logic      rst_n,
    mtr_drv_if.slave bus
);

    localparam logic [10:0] NOV11 = 11'(NONOVERLAP);
    localparam logic [11:0] NOV12 = 12'(NONOVERLAP);
    localparam logic [7:0]  BLK8  = 8'(BLANK);
    localparam logic [2:0]  LIM3  = 3'(OVR_LIMIT);

    // Index 0 is the left side, index 1 the right side.
    logic [10:0]      cnt_q, cnt_d;
    logic [1:0][10:0] duty_q, duty_d;
    logic [1:0]       pwm1_q, pwm1_d;
    logic [1:0]       pwm2_q, pwm2_d;
    logic [1:0][1:0]  sync_q, sync_d;
    logic [1:0][7:0]  on_q, on_d;
    logic             seen_q, seen_d;
    logic [2:0]       ovr_q, ovr_d;
    logic             sd_q, sd_d;
    logic             synch_q, synch_d;
    logic             wrap;
    logic             seen_now;
    logic [2:0]       ovr_inc;
    logic [1:0]       qual;
    logic [1:0]       ovr_in;
    logic [1:0][11:0] spd;

    assign spd    = {bus.rght_spd, bus.lft_spd};
    assign ovr_in = {bus.OVR_I_rght, bus.OVR_I_lft};

    always_comb begin
        wrap   = (cnt_q == 11'h7FF);
        cnt_d  = cnt_q + 11'd1;
        duty_d = duty_q;
        sync_d = sync_q;
        on_d   = on_q;
        qual   = '0;
        pwm1_d = '0;
        pwm2_d = '0;
        for (int s = 0; s < 2; s++) begin
            sync_d[s] = {sync_q[s][0], ovr_in[s]};
            qual[s]   = sync_q[s][1] && (on_q[s] >= BLK8);
            if (!(pwm1_q[s] || pwm2_q[s])) begin
                on_d[s] = 8'd0;
            end else if (on_q[s] != 8'hFF) begin
                on_d[s] = on_q[s] + 8'd1;
            end
            if (wrap) begin
                duty_d[s] = {~spd[s][11], spd[s][10:1]};
            end
        end
        seen_now = seen_q || (|qual);
        seen_d   = seen_now && !wrap;
        ovr_inc  = ovr_q + 3'd1;
        ovr_d    = ovr_q;
        sd_d     = sd_q;
        if (wrap) begin
            ovr_d = seen_now ? ovr_inc : 3'd0;
            if (seen_now && (ovr_inc == LIM3)) begin
                sd_d = 1'b1;
            end
        end
        // Gate on the next shutdown state so legs drop the cycle after the trip edge.
        for (int s = 0; s < 2; s++) begin
            pwm2_d[s] = !sd_d && (cnt_q >= NOV11)
                        && (cnt_q < duty_q[s]);
            pwm1_d[s] = !sd_d
                        && ({1'b0, cnt_q} >= ({1'b0, duty_q[s]} + NOV12));
        end
        synch_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            duty_q  <= {2{11'd1024}};
            pwm1_q  <= '0;
            pwm2_q  <= '0;
            sync_q  <= '0;
            on_q    <= '0;
            seen_q  <= 1'b0;
            ovr_q   <= '0;
            sd_q    <= 1'b0;
            synch_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            pwm1_q  <= pwm1_d;
            pwm2_q  <= pwm2_d;
            sync_q  <= sync_d;
            on_q    <= on_d;
            seen_q  <= seen_d;
            ovr_q   <= ovr_d;
            sd_q    <= sd_d;
            synch_q <= synch_d;
        end
    end

    assign bus.PWM1_lft     = pwm1_q[0];
    assign bus.PWM2_lft     = pwm2_q[0];
    assign bus.PWM1_rght    = pwm1_q[1];
    assign bus.PWM2_rght    = pwm2_q[1];
    assign bus.pwm_synch    = synch_q;
    assign bus.OVR_I_shtdwn = sd_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Period-level scoreboard bench for mtr_drv: per-period leg high counts,
// dead time, period length and shutdown flag against a duty/flag model.
module tb_mtr_drv;

    localparam int NOV = 32;
    localparam int PER = 2048;
    localparam int LIM = 4;

    typedef struct {
        int dl;
        int dr;
        bit sd_pre;
        bit sd_post;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    mtr_drv_if bus();

    mtr_drv #(
        .NONOVERLAP(NOV),
        .BLANK(128),
        .OVR_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cur_dl = 1024;
    int cur_dr = 1024;
    int cons = 0;
    bit sd = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic int duty_of(input int spd);
        return (spd + 2048) / 2;
    endfunction

    function automatic int hi2(input int d);
        return (d > NOV) ? d - NOV : 0;
    endfunction

    function automatic int hi1(input int d);
        return (PER - d - NOV > 0) ? PER - d - NOV : 0;
    endfunction

    function automatic int rnd_full();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    function automatic int rnd_mid();
        return int'($urandom_range(2300)) - 1200;
    endfunction

    // ot: 0 none, 1 rght held, 2 lft held, 3 short lft pulse in blanking
    task automatic run_period(input int sl, input int sr, input int chg,
                              input int sl2, input int ot);
        int nl;
        bit fl;
        bit pre;
        for (int c = 0; c < PER; c++) begin
            if (c == 0) begin
                bus.lft_spd  = 12'(sl);
                bus.rght_spd = 12'(sr);
            end
            if (c == chg) bus.lft_spd = 12'(sl2);
            bus.OVR_I_rght = (ot == 1) && (c >= 100) && (c < 1900);
            bus.OVR_I_lft  = ((ot == 2) && (c >= 100) && (c < 1900))
                             || ((ot == 3) && (c >= 81) && (c < 84));
            @(posedge clk);
            #1;
        end
        nl   = (chg >= 0) ? sl2 : sl;
        fl   = (ot == 1) || (ot == 2);
        pre  = sd;
        cons = fl ? cons + 1 : 0;
        if (cons >= LIM) sd = 1'b1;
        sb.push_back('{cur_dl, cur_dr, pre, sd});
        cur_dl = duty_of(nl);
        cur_dr = duty_of(sr);
    endtask

    // Monitor: accumulate one window of outputs, score it at each pwm_synch.
    initial begin
        int len;
        int c1[2];
        int c2[2];
        int viol[2];
        int gap[2];
        bit q1[2];
        bit q2[2];
        bit p1[2];
        bit p2[2];
        exp_t e;
        len = 0;
        forever begin
            @(negedge clk);
            p1[0] = bus.PWM1_lft;
            p2[0] = bus.PWM2_lft;
            p1[1] = bus.PWM1_rght;
            p2[1] = bus.PWM2_rght;
            if (!rst_n) begin
                len = 0;
                for (int s = 0; s < 2; s++) begin
                    c1[s] = 0; c2[s] = 0; viol[s] = 0;
                    gap[s] = 10000; q1[s] = 0; q2[s] = 0;
                end
            end else begin
                len++;
                for (int s = 0; s < 2; s++) begin
                    if (p1[s]) c1[s]++;
                    if (p2[s]) c2[s]++;
                    if (p1[s] && p2[s]) viol[s]++;
                    if (p1[s] && !q1[s] && gap[s] < NOV) viol[s]++;
                    if (p2[s] && !q2[s] && gap[s] < NOV) viol[s]++;
                    gap[s] = (p1[s] || p2[s]) ? 0 : gap[s] + 1;
                    q1[s] = p1[s];
                    q2[s] = p2[s];
                end
                if (bus.pwm_synch) begin
                    check("sb_nonempty", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("period_len", len, PER);
                        check("shtdwn", bus.OVR_I_shtdwn, e.sd_post);
                        check("legs_l", viol[0], 0);
                        check("legs_r", viol[1], 0);
                        if (e.sd_pre) begin
                            check("sd_pwm1_l", c1[0], 0);
                            check("sd_pwm2_l", c2[0], 0);
                            check("sd_pwm1_r", c1[1], 0);
                            check("sd_pwm2_r", c2[1], 0);
                        end else if (!e.sd_post) begin
                            check("pwm1_l", c1[0], hi1(e.dl));
                            check("pwm2_l", c2[0], hi2(e.dl));
                            check("pwm1_r", c1[1], hi1(e.dr));
                            check("pwm2_r", c2[1], hi2(e.dr));
                        end
                    end
                    len = 0;
                    for (int s = 0; s < 2; s++) begin
                        c1[s] = 0; c2[s] = 0; viol[s] = 0;
                    end
                end
            end
        end
    end

    initial begin
        bus.lft_spd    = '0;
        bus.rght_spd   = '0;
        bus.OVR_I_lft  = 1'b0;
        bus.OVR_I_rght = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm1_l", bus.PWM1_lft, 0);
        check("rst_pwm2_l", bus.PWM2_lft, 0);
        check("rst_pwm1_r", bus.PWM1_rght, 0);
        check("rst_pwm2_r", bus.PWM2_rght, 0);
        check("rst_synch", bus.pwm_synch, 0);
        check("rst_shtdwn", bus.OVR_I_shtdwn, 0);
        #1 rst_n = 1'b1;

        run_period(0, 0, -1, 0, 0);
        run_period(2047, -2048, -1, 0, 0);
        run_period(0, 0, -1, 0, 0);
        run_period(0, 0, 500, 600, 0);
        for (int i = 0; i < 4; i++)
            run_period(rnd_full(), rnd_full(),
                       int'($urandom_range(1, 2000)), rnd_full(), 0);
        for (int i = 0; i < 10; i++)
            run_period(rnd_mid(), rnd_mid(), -1, 0, 3);
        for (int i = 0; i < 3; i++)
            run_period(rnd_mid(), rnd_mid(), -1, 0, 2);
        run_period(rnd_mid(), rnd_mid(), -1, 0, 0);
        for (int i = 0; i < 3; i++)
            run_period(rnd_mid(), rnd_mid(), -1, 0, 1);
        run_period(rnd_mid(), rnd_mid(), -1, 0, 0);
        for (int i = 0; i < 4; i++)
            run_period(rnd_mid(), rnd_mid(), -1, 0, 1);
        run_period(rnd_full(), rnd_full(), -1, 0, 0);
        run_period(rnd_full(), rnd_full(), -1, 0, 0);

        repeat (700) begin
            @(posedge clk);
            #1;
        end
        check("sd_before_rst", bus.OVR_I_shtdwn, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_pwm1_l", bus.PWM1_lft, 0);
        check("mrst_pwm2_l", bus.PWM2_lft, 0);
        check("mrst_pwm1_r", bus.PWM1_rght, 0);
        check("mrst_pwm2_r", bus.PWM2_rght, 0);
        check("mrst_shtdwn", bus.OVR_I_shtdwn, 0);
        sd     = 1'b0;
        cons   = 0;
        cur_dl = 1024;
        cur_dr = 1024;
        bus.lft_spd  = '0;
        bus.rght_spd = '0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        run_period(0, 0, -1, 0, 0);
        run_period(rnd_full(), rnd_full(), -1, 0, 0);
        @(negedge clk);
        #2;
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mtr_drv.md
# mtr_drv

Motor drive block at the far end of the speed path. It takes the saturated signed wheel speeds produced by the balance controller and converts each one into a complementary pair of 11-bit PWM half-bridge drives with dead time. It also supervises the two over-current comparators and latches a shutdown. It sits between the balance controller and the H-bridge gate drivers.

## Interface
Parameters:
- NONOVERLAP, 32: dead-time in clocks between one leg falling and the complementary leg rising; legal range 1..255.
- BLANK, 128: clocks after a PWM pulse begins during which the over-current input is ignored.
- OVR_LIMIT, 4: number of consecutive PWM periods with a qualified over-current event that causes shutdown.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- lft_spd  in  12  signed left speed, -2048..2047.
- rght_spd  in  12  signed right speed, -2048..2047.
- OVR_I_lft  in  1  left over-current comparator, asynchronous to clk.
- OVR_I_rght  in  1  right over-current comparator, asynchronous to clk.
- PWM1_lft, PWM2_lft  out  1 each  left reverse and forward leg drives.
- PWM1_rght, PWM2_rght  out  1 each  right reverse and forward leg drives.
- pwm_synch  out  1  one-clock pulse at the start of each PWM period, used for ADC sampling alignment.
- OVR_I_shtdwn  out  1  sticky over-current shutdown flag.

## Operation
- Period counter `cnt`:
  - 11-bit free-running counter, 0..2047, wraps to 0.
  - PWM period is 2048 clocks.
- Duty mapping, per side: duty = {~spd[11], spd[10:1]}, i.e. (spd+2048)>>1, unsigned 11 bits.
  - -2048 maps to 0.
  - 0 maps to 1024.
  - 2047 maps to 2047.
- Duty registers `duty_q`:
  - Loaded only on the edge where cnt==2047, so each period uses one constant duty.
  - A speed change mid-period has no effect until the next period.
- Per side, all outputs are registered and computed from pre-edge values:
  - PWM2 <= (cnt >= NONOVERLAP) && (cnt < duty_q).
  - PWM1 <= ({1'b0,cnt} >= duty_q + NONOVERLAP). This sum is 12-bit unsigned; if it is 2048 or more, PWM1 stays low for the whole period.
  - PWM1 and PWM2 of one side are never high in the same cycle. There are at least NONOVERLAP low cycles between them in both directions, including across the period wrap.
  - duty_q < NONOVERLAP gives PWM2 low for the whole period.
- pwm_synch <= (cnt == 2047). It is high in the first cycle of each period.
- Over-current supervision, per side:
  - OVR_I_x goes through a 2-flop synchronizer.
  - An 8-bit on-timer resets to 0 when both legs of that side are low. It increments, saturating at 255, while either leg is high.
  - A qualified event is: synchronized OVR_I_x high AND on-timer >= BLANK.
  - `ovr_seen` is set by a qualified event on either side and cleared at each period end.
  - `ovr_cnt` is a 3-bit counter updated on the edge where cnt==2047:
    - If ovr_seen (including an event in that same cycle), ovr_cnt increments.
    - Otherwise ovr_cnt returns to 0.
  - When the increment reaches OVR_LIMIT, OVR_I_shtdwn is set on that same edge.
- Shutdown behaviour:
  - OVR_I_shtdwn is sticky; only rst_n clears it.
  - While it is set, all four PWM outputs are 0.
  - cnt and pwm_synch keep running.

## Timing
- Reset values:
  - cnt = 0.
  - duty_q = 1024 (zero speed) on both sides.
  - All PWM outputs = 0, pwm_synch = 0, OVR_I_shtdwn = 0.
  - ovr_cnt = 0, ovr_seen = 0, on-timers = 0, synchronizers = 0.
- Latency:
  - A speed sampled at the cnt==2047 edge drives outputs from the first cycle of the next period, with one clock of register delay relative to cnt.
  - Worst-case latency from a speed change to a PWM effect is 2049 clocks.
- Output shape:
  - PWM2 is high for max(0, duty_q - NONOVERLAP) cycles per period.
  - PWM1 is high for max(0, 2048 - duty_q - NONOVERLAP) cycles per period.
- Over-current latency:
  - The synchronizer adds 2 clocks.
  - The shutdown edge is the cnt==2047 edge of the OVR_LIMIT-th consecutive flagged period.
  - Outputs are 0 from the following cycle.
- Reset mid-period: all state returns to reset values immediately, and outputs go low asynchronously.
- Simultaneous events: when the left and right sides both qualify in one period, the period counts once.

## Test plan
- Zero speed with the default parameters -> per 2048-clock period:
  - PWM2_lft is high for 992 cycles, PWM1_lft for 992 cycles.
  - Each leg has 32 low cycles before it rises.
  - pwm_synch occurs every 2048 clocks.
- lft_spd = 2047, rght_spd = -2048 -> PWM2_lft is high for 2015 cycles and PWM1_lft never. PWM1_rght is high for 2016 cycles and PWM2_rght never. The checker asserts no overlap throughout.
- lft_spd stepped from 0 to 600 at cnt==500 -> the current period keeps duty 1024; the next period shows PWM2_lft high for 1292 cycles.
- OVR_I_lft pulsed at on-timer 50 in 10 consecutive periods -> it is always blanked, and OVR_I_shtdwn stays 0.
- OVR_I_rght held high in 4 consecutive periods -> OVR_I_shtdwn rises at the end of the 4th period and all PWM outputs are 0 after it. With 3 flagged periods, then 1 clean period, then 3 flagged periods, there is no shutdown.
- rst_n asserted mid-period while in shutdown -> outputs 0 and flag cleared. After release, the first pwm_synch occurs 2048 clocks later with duty 1024.
